// File: rtl/shift_rows_serial.sv
// shift_rows_serial
//   Byte-serial forward AES ShiftRows. A 16-byte state arrives column-major
//   (byte k = s[k%4][k/4]) and is emitted with row r rotated left by r.
//   Two block buffers alternate: one fills while the other drains, which
//   allows a sustained rate of 1 byte/cycle.
//
// Ports
//   clk, n_rst    system clock (rising edge), asynchronous active-low reset
//   clear         synchronous flush of both buffers and all pointers
//   in_data       state byte; in_valid / in_ready handshake
//   in_bypass     sampled with byte 0 of a block; 1 = pass block unshifted
//   out_data      shifted state byte; out_valid / out_ready handshake
//   out_last      marks byte 15 of each output block
//   blocks_done   completed-block counter, CNT_W bits wide (only present
//                 when SHIFT_ROWS_SERIAL_COUNT_EN is defined)
//
// Build option
//   SHIFT_ROWS_SERIAL_COUNT_EN : adds the blocks_done port and its counter.
module shift_rows_serial #(
   parameter int CNT_W = 16
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       clear,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_bypass,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last
`ifdef SHIFT_ROWS_SERIAL_COUNT_EN
   ,
   output logic [CNT_W-1:0] blocks_done
`endif
);

   logic [7:0] mem_q [2][16];
   logic [1:0] full_q, full_d;
   logic [1:0] byp_q, byp_d;
   logic       wr_buf_q, wr_buf_d;
   logic       rd_buf_q, rd_buf_d;
   logic [3:0] wr_cnt_q, wr_cnt_d;
   logic [3:0] rd_cnt_q, rd_cnt_d;
   logic [7:0] hold_q, hold_d;

   logic       in_fire;
   logic       out_fire;
   logic [1:0] src_col;
   logic [3:0] rd_idx;

   assign in_ready  = ~full_q[wr_buf_q];
   assign out_valid = full_q[rd_buf_q];
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   // Output byte k (row r, column c) comes from input column (c+r) mod 4,
   // same row; the 2-bit add wraps for free.
   assign src_col  = rd_cnt_q[3:2] + rd_cnt_q[1:0];
   assign rd_idx   = byp_q[rd_buf_q] ? rd_cnt_q : {src_col, rd_cnt_q[1:0]};

   // With no block ready the last emitted byte is held so out_data never
   // wanders while out_valid is low.
   assign out_data = out_valid ? mem_q[rd_buf_q][rd_idx] : hold_q;
   assign out_last = out_valid & (rd_cnt_q == 4'd15);

   always_comb begin
      full_d   = full_q;
      byp_d    = byp_q;
      wr_buf_d = wr_buf_q;
      rd_buf_d = rd_buf_q;
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      hold_d   = hold_q;
      if (clear) begin
         full_d   = 2'b00;
         byp_d    = 2'b00;
         wr_buf_d = 1'b0;
         rd_buf_d = 1'b0;
         wr_cnt_d = 4'd0;
         rd_cnt_d = 4'd0;
         hold_d   = 8'h00;
      end else begin
         // A write and a read can never target the same buffer: writing
         // needs it empty, reading needs it full.
         if (in_fire) begin
            wr_cnt_d = wr_cnt_q + 4'd1;
            if (wr_cnt_q == 4'd0) begin
               byp_d[wr_buf_q] = in_bypass;
            end
            if (wr_cnt_q == 4'd15) begin
               full_d[wr_buf_q] = 1'b1;
               wr_buf_d         = ~wr_buf_q;
            end
         end
         if (out_fire) begin
            rd_cnt_d = rd_cnt_q + 4'd1;
            if (rd_cnt_q == 4'd15) begin
               full_d[rd_buf_q] = 1'b0;
               rd_buf_d         = ~rd_buf_q;
               hold_d           = out_data;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         full_q   <= 2'b00;
         byp_q    <= 2'b00;
         wr_buf_q <= 1'b0;
         rd_buf_q <= 1'b0;
         wr_cnt_q <= 4'd0;
         rd_cnt_q <= 4'd0;
         hold_q   <= 8'h00;
      end else begin
         full_q   <= full_d;
         byp_q    <= byp_d;
         wr_buf_q <= wr_buf_d;
         rd_buf_q <= rd_buf_d;
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
         hold_q   <= hold_d;
      end
   end

   // Buffer storage carries no reset; only the full flags qualify it.
   always_ff @(posedge clk) begin
      if (in_fire && !clear) begin
         mem_q[wr_buf_q][wr_cnt_q] <= in_data;
      end
   end

`ifdef SHIFT_ROWS_SERIAL_COUNT_EN
   logic [CNT_W-1:0] blocks_done_q;

   // Survives clear; only n_rst zeroes it.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         blocks_done_q <= '0;
      end else if (out_fire && out_last && !clear) begin
         blocks_done_q <= blocks_done_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign blocks_done = blocks_done_q;
`endif

endmodule

// File: tb/tb_shift_rows_serial.sv
module tb_shift_rows_serial;

   localparam int CNT_W = 16;

   logic       clk = 1'b0;
   logic       n_rst, clear;
   logic [7:0] in_data, out_data;
   logic       in_valid, in_ready, in_bypass;
   logic       out_valid, out_ready, out_last;
   logic       dir_ready, rnd_ready, rand_en;
`ifdef SHIFT_ROWS_SERIAL_COUNT_EN
   logic [CNT_W-1:0] blocks_done;
`endif

   assign out_ready = rand_en ? rnd_ready : dir_ready;

   shift_rows_serial #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .clear      (clear),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_bypass  (in_bypass),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last)
`ifdef SHIFT_ROWS_SERIAL_COUNT_EN
      ,
      .blocks_done(blocks_done)
`endif
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always begin
      @(posedge clk);
      #1;
      if (rand_en) rnd_ready = 1'($urandom_range(0, 1));
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no summary expected summary");
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   // Blocks are collected as byte queues; a completed block is expanded with
   // the ShiftRows rule into a queue of expected output bytes.
   logic [7:0] cur_q[$];
   logic [7:0] exp_q[$];
   bit         cur_byp;
   logic [7:0] last_byte;
   int         done_cnt;

   function automatic void finish_block();
      int c, r, src;
      for (int k = 0; k < 16; k++) begin
         c   = k / 4;
         r   = k % 4;
         src = cur_byp ? k : 4 * ((c + r) % 4) + r;
         exp_q.push_back(cur_q[src]);
      end
      cur_q.delete();
   endfunction

   always @(negedge clk) begin : monitor
      int nfull;
      if (!n_rst) begin
         cur_q.delete();
         exp_q.delete();
         last_byte = 8'h00;
         done_cnt  = 0;
      end else begin
         nfull = (exp_q.size() + 15) / 16;
         check("mon_in_ready", int'(in_ready), int'(nfull < 2));
         check("mon_out_valid", int'(out_valid), int'(nfull > 0));
         check("mon_out_last", int'(out_last), int'(nfull > 0 && exp_q.size() % 16 == 1));
         if (nfull > 0) check("mon_out_data", int'(out_data), int'(exp_q[0]));
         else check("mon_out_hold", int'(out_data), int'(last_byte));
`ifdef SHIFT_ROWS_SERIAL_COUNT_EN
         check("mon_blocks_done", int'(blocks_done), done_cnt % (1 << CNT_W));
`endif
         if (clear) begin
            cur_q.delete();
            exp_q.delete();
            last_byte = 8'h00;
         end else begin
            if (in_valid && in_ready) begin
               if (cur_q.size() == 0) cur_byp = in_bypass;
               cur_q.push_back(in_data);
               if (cur_q.size() == 16) finish_block();
            end
            if (out_valid && out_ready && nfull > 0) begin
               if (exp_q.size() % 16 == 1) begin
                  last_byte = exp_q[0];
                  done_cnt++;
               end
               void'(exp_q.pop_front());
            end
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic put_byte(input logic [7:0] d, input logic byp, input int bound, output bit ok);
      int w;
      in_data   = d;
      in_bypass = byp;
      in_valid  = 1'b1;
      ok = 0;
      w  = 0;
      while (!ok && w < bound) begin
         if (in_ready) ok = 1;
         @(posedge clk);
         #1;
         w++;
      end
   endtask

   // Leaves in_valid high so consecutive blocks can go back to back; the
   // caller drops it.
   task automatic send_block(input logic [127:0] blk, input logic byp);
      bit ok, all_ok;
      all_ok = 1;
      for (int k = 0; k < 16; k++) begin
         put_byte(blk[127-8*k -: 8], (k == 0) ? byp : ~byp, 200, ok);
         if (!ok) all_ok = 0;
      end
      check("send_block_accepted", int'(all_ok), 1);
   endtask

   task automatic get_byte(output logic [7:0] d, output logic last, output int waited, output bit ok);
      dir_ready = 1'b1;
      waited = 0;
      ok = 0;
      d = 8'h00;
      last = 1'b0;
      while (!out_valid && waited < 200) begin
         @(posedge clk);
         #1;
         waited++;
      end
      if (out_valid) begin
         ok   = 1;
         d    = out_data;
         last = out_last;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic recv_block(input logic [127:0] exp, input string name);
      logic [7:0] d;
      logic       last;
      int         waited;
      bit         ok;
      for (int k = 0; k < 16; k++) begin
         get_byte(d, last, waited, ok);
         check({name, "_got_byte"}, int'(ok), 1);
         check({name, "_data"}, int'(d), int'(exp[127-8*k -: 8]));
         check({name, "_last"}, int'(last), int'(k == 15));
      end
   endtask

   typedef struct packed {
      logic [127:0] in_blk;
      logic         byp;
      logic [127:0] exp_blk;
   } vec_t;

   vec_t tab[4];

   initial begin : main
      bit          ok;
      int          acc, t0, bubbles, waited, got, wait_cnt;
      logic [7:0]  d;
      logic        last;
      logic [127:0] blk;
`ifdef SHIFT_ROWS_SERIAL_COUNT_EN
      int          done0;
`endif

      tab[0] = '{128'h000102030405060708090A0B0C0D0E0F, 1'b0, 128'h00050A0F04090E03080D02070C01060B};
      tab[1] = '{128'h000102030405060708090A0B0C0D0E0F, 1'b1, 128'h000102030405060708090A0B0C0D0E0F};
      tab[2] = '{128'h101112131415161718191A1B1C1D1E1F, 1'b0, 128'h10151A1F14191E13181D12171C11161B};
      tab[3] = '{128'h00112233445566778899AABBCCDDEEFF, 1'b0, 128'h0055AAFF4499EE3388DD2277CC1166BB};

      n_rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_bypass = 1'b0;
      dir_ready = 1'b1; rnd_ready = 1'b0; rand_en = 1'b0;

      #2 n_rst = 1'b0;
      #1;
      check("reset_in_ready", int'(in_ready), 1);
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_out_last", int'(out_last), 0);
      check("reset_out_data", int'(out_data), 0);
`ifdef SHIFT_ROWS_SERIAL_COUNT_EN
      check("reset_blocks_done", int'(blocks_done), 0);
`endif
      @(posedge clk); @(posedge clk); #1;
      n_rst = 1'b1;
      @(posedge clk); #1;

      // Directed blocks: bypass then unshifted confirms the per-block latch.
      for (int i = 0; i < 4; i++) begin
         send_block(tab[i].in_blk, tab[i].byp);
         in_valid = 1'b0;
         check("latency_out_valid", int'(out_valid), 1);
         recv_block(tab[i].exp_blk, "table");
      end

      // Three back-to-back blocks at full rate.
      dir_ready = 1'b1;
`ifdef SHIFT_ROWS_SERIAL_COUNT_EN
      done0 = done_cnt;
`endif
      t0 = cyc;
      bubbles = 0;
      got = 0;
      fork
         begin
            for (int b = 0; b < 3; b++) begin
               blk = {$urandom, $urandom, $urandom, $urandom};
               send_block(blk, 1'b0);
            end
            in_valid = 1'b0;
            check("b2b_input_cycles", cyc - t0, 48);
         end
         begin
            for (int k = 0; k < 48; k++) begin
               get_byte(d, last, waited, ok);
               if (ok) got++;
               if (k > 0) bubbles += waited;
            end
         end
      join
      check("b2b_bytes_out", got, 48);
      check("b2b_bubbles", bubbles, 0);
`ifdef SHIFT_ROWS_SERIAL_COUNT_EN
      check("b2b_blocks_done_delta", done_cnt - done0, 3);
`endif

      // Downstream stalled: two blocks fill, then back-pressure.
      dir_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 40; i++) begin
         put_byte(8'(i), 1'b0, 3, ok);
         if (!ok) break;
         acc++;
      end
      in_valid = 1'b0;
      check("stall_accepted", acc, 32);
      check("stall_in_ready", int'(in_ready), 0);
      dir_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         @(posedge clk); #1;
         check("stall_release_in_ready", int'(in_ready), int'(k == 15));
      end
      repeat (16) begin @(posedge clk); #1; end
      check("stall_drained", int'(out_valid), 0);

      // Asynchronous reset with one full block and 7 bytes of the next.
      dir_ready = 1'b0;
      send_block(tab[3].in_blk, 1'b0);
      for (int i = 0; i < 7; i++) put_byte(8'hA0 + 8'(i), 1'b0, 10, ok);
      in_valid = 1'b0;
      check("pre_reset_out_valid", int'(out_valid), 1);
      #3 n_rst = 1'b0;
      #1;
      check("async_rst_in_ready", int'(in_ready), 1);
      check("async_rst_out_valid", int'(out_valid), 0);
      check("async_rst_out_last", int'(out_last), 0);
      check("async_rst_out_data", int'(out_data), 0);
      @(negedge clk);
      #2 n_rst = 1'b1;
      @(posedge clk); #1;
      dir_ready = 1'b1;
      send_block(tab[0].in_blk, 1'b0);
      in_valid = 1'b0;
      recv_block(tab[0].exp_blk, "after_reset");

      // clear together with the 16th input byte.
      for (int k = 0; k < 15; k++) put_byte(8'h50 + 8'(k), 1'b0, 10, ok);
      clear = 1'b1;
      put_byte(8'h5F, 1'b0, 10, ok);
      clear = 1'b0;
      in_valid = 1'b0;
      check("clear_in_ready", int'(in_ready), 1);
      check("clear_out_valid", int'(out_valid), 0);
      repeat (3) begin @(posedge clk); #1; end
      check("clear_no_late_valid", int'(out_valid), 0);
      send_block(tab[2].in_blk, 1'b0);
      in_valid = 1'b0;
      recv_block(tab[2].exp_blk, "after_clear");

      // Random traffic, checked by the model in the monitor.
      rand_en = 1'b1;
      for (int b = 0; b < 8; b++) begin
         for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 3) == 0) begin
               in_valid = 1'b0;
               @(posedge clk); #1;
            end
            put_byte(8'($urandom), 1'($urandom_range(0, 1)), 400, ok);
            check("rand_put", int'(ok), 1);
         end
      end
      in_valid = 1'b0;
      wait_cnt = 0;
      while ((exp_q.size() != 0 || out_valid) && wait_cnt < 400) begin
         @(posedge clk); #1;
         wait_cnt++;
      end
      check("rand_drained", int'(exp_q.size()), 0);
      rand_en = 1'b0;
      repeat (2) begin @(posedge clk); #1; end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
